rgb_value_digit_ctrl: RTL
=========================

Name: rgb_value_digit_ctrl

Overview:
- Controller that feeds the RGB value display's digit glyph ROMs.
- Converts three 8-bit channel values (R, G, B) into hundreds/tens/units BCD digits with a sequential double-dabble engine, one time-shared across the three channels.
- Commits all nine digits atomically, optionally only at frame start so the screen never tears.
- Generates the glyph row address (0–15) and row-valid flag for the character band from VGA line/frame strobes.

Parameters:
- Y0, 200, first video line of the 16-line digit band.
- SYNC_COMMIT, 1, 1 = digit commit waits for frame_stb; 0 = commit immediately.

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- upd  in  1  request a conversion of val_r/val_g/val_b; sampled every cycle
- val_r  in  8  red channel value
- val_g  in  8  green channel value
- val_b  in  8  blue channel value
- line_stb  in  1  one-cycle pulse per video line
- frame_stb  in  1  one-cycle pulse at frame start (vertical blank)
- busy  out  1  high from request accept until commit
- done  out  1  one-cycle pulse in the cycle after digits commit
- dig_r_h, dig_r_d, dig_r_u  out  4 each  red hundreds/tens/units digit
- dig_g_h, dig_g_d, dig_g_u  out  4 each  green digits
- dig_b_h, dig_b_d, dig_b_u  out  4 each  blue digits
- row_addr  out  4  glyph row index, fed to every glyph ROM row port
- row_valid  out  1  current line lies within [Y0, Y0+15]

Behaviour:
- Reset (clr_n=0, async):
  - state IDLE; all dig_* = 0; busy = 0, done = 0, pending = 0.
  - Line counter = 0; row_addr = 0; row_valid = 0.
  - Reset mid-conversion abandons the work; digits stay 0 until a full new conversion commits.
- FSM states IDLE, CONV, WAIT, COMMIT:
  - IDLE: upd=1 at edge k → latch all three values, channel index = 0, iteration count = 0, go to CONV, busy=1 from k.
  - CONV: one double-dabble iteration per cycle on the 20-bit register {bcd[11:0], bin[7:0]}.
    - Each iteration: add 3 to every BCD nibble ≥ 5, then shift the whole register left by 1, both in the same cycle.
    - After 8 iterations, store the 3 nibbles into the channel's shadow registers, clear the register, load the next channel.
    - R is converted first, then G, then B: 24 CONV cycles, edges k+1..k+24.
    - Then go to WAIT if SYNC_COMMIT=1, otherwise to COMMIT.
  - WAIT: hold until frame_stb=1, then go to COMMIT. A frame_stb coinciding with the transition into WAIT is not counted.
  - COMMIT: all 9 dig_* load from the shadow registers at the same edge, busy=0, done=1 for the next cycle only.
    - If pending=1, clear it and go straight to CONV with freshly latched values (busy stays 1, done still pulses).
    - Otherwise go to IDLE.
- SYNC_COMMIT=0 latency: upd accepted at edge k → dig_* update at edge k+25; done high during cycle k+25..k+26.
- upd while busy sets pending. Multiple requests collapse into one. Input values are sampled at restart, not at request time.
- dig_* never change outside the COMMIT edge. All digit values are ≤ 9; hundreds ≤ 2.
- Row generator:
  - frame_stb → line counter = 0; line_stb → counter + 1.
  - The counter is 10 bits and saturates at 1023.
  - If frame_stb and line_stb arrive together, frame_stb wins and the counter becomes 0.
  - row_valid = (line ≥ Y0) && (line < Y0+16); row_addr = (line − Y0)[3:0] when valid, else 0. Both are registered, so they are one cycle after the counter.

Test Plan:
- SYNC_COMMIT=0; val_r=255, val_g=0, val_b=128; upd pulse at edge k → busy 1 from k; at edge k+25 dig_r = 2,5,5, dig_g = 0,0,0, dig_b = 1,2,8; done for one cycle; busy 0.
- Sweep 0..255 on all channels with random mixes → hundreds*100 + tens*10 + units equals the input value for every channel.
- upd pulsed 3 times during a conversion with values changed to 99/100/7 → exactly one restart after the first commit; second commit shows 0,9,9 / 1,0,0 / 0,0,7; done pulses twice.
- SYNC_COMMIT=1; conversion finishes, frame_stb delayed 50 cycles → dig_* unchanged and busy=1 until the frame_stb edge, then commit and done.
- clr_n dropped at CONV cycle 10 → outputs 0 immediately; after release, no done and dig_* stay 0 until a new upd completes.
- Y0=200; frame_stb then 215 line_stb pulses → row_valid 1 with row_addr 0..15 on lines 200..215, 0 elsewhere; frame_stb together with line_stb → counter 0.

Source files
------------

// File: rtl/rgb_value_digit_ctrl.sv
// BCD digit controller for the RGB value display: one shared double-dabble engine
// converts R, G and B in turn, commits all nine digits at once, and generates glyph row addresses.
module rgb_value_digit_ctrl #(
    parameter int Y0          = 200,
    parameter bit SYNC_COMMIT = 1'b1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       upd,
    input  logic [7:0] val_r,
    input  logic [7:0] val_g,
    input  logic [7:0] val_b,
    input  logic       line_stb,
    input  logic       frame_stb,
    output logic       busy,
    output logic       done,
    output logic [3:0] dig_r_h,
    output logic [3:0] dig_r_d,
    output logic [3:0] dig_r_u,
    output logic [3:0] dig_g_h,
    output logic [3:0] dig_g_d,
    output logic [3:0] dig_g_u,
    output logic [3:0] dig_b_h,
    output logic [3:0] dig_b_d,
    output logic [3:0] dig_b_u,
    output logic [3:0] row_addr,
    output logic       row_valid
);

    typedef enum logic [1:0] {IDLE, CONV, WAIT, COMMIT} state_t;

    localparam logic [10:0] Y0_W   = 11'(Y0);
    localparam logic [10:0] Y0_END = 11'(Y0 + 16);
    localparam logic [3:0]  Y0_LO  = 4'(Y0);

    state_t      state, state_nxt;
    logic [1:0]  ch;
    logic [2:0]  iter;
    logic        pending;
    logic        start;
    logic [7:0]  lat_r, lat_g, lat_b;
    logic [19:0] sr, sr_step;
    logic [11:0] sh_r, sh_g, sh_b;
    logic [9:0]  line;
    logic        in_band;

    // One double-dabble iteration: +3 on every BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dd_step(input logic [19:0] x);
        logic [19:0] y;
        y = x;
        for (int i = 0; i < 3; i++) begin
            if (y[8+4*i +: 4] >= 4'd5)
                y[8+4*i +: 4] = y[8+4*i +: 4] + 4'd3;
        end
        return {y[18:0], 1'b0};
    endfunction

    assign sr_step = dd_step(sr);
    assign start   = ((state == IDLE) && upd) || ((state == COMMIT) && (pending || upd));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (upd) state_nxt = CONV;
            CONV:   if ((iter == 3'd7) && (ch == 2'd2))
                        state_nxt = SYNC_COMMIT ? WAIT : COMMIT;
            WAIT:   if (frame_stb) state_nxt = COMMIT;
            COMMIT: state_nxt = (pending || upd) ? CONV : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            ch      <= 2'd0;
            iter    <= 3'd0;
            pending <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dig_r_h <= 4'd0; dig_r_d <= 4'd0; dig_r_u <= 4'd0;
            dig_g_h <= 4'd0; dig_g_d <= 4'd0; dig_g_u <= 4'd0;
            dig_b_h <= 4'd0; dig_b_d <= 4'd0; dig_b_u <= 4'd0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state == COMMIT);
            if (start) begin
                ch   <= 2'd0;
                iter <= 3'd0;
            end else if (state == CONV) begin
                iter <= iter + 3'd1;
                if (iter == 3'd7) ch <= ch + 2'd1;
            end
            // A request during the restart cycle is consumed by that restart.
            if (start)
                pending <= 1'b0;
            else if (busy && upd)
                pending <= 1'b1;
            if (state == COMMIT) begin
                {dig_r_h, dig_r_d, dig_r_u} <= sh_r;
                {dig_g_h, dig_g_d, dig_g_u} <= sh_g;
                {dig_b_h, dig_b_d, dig_b_u} <= sh_b;
            end
        end
    end

    // Datapath registers need no reset: digits only load after a complete conversion.
    always_ff @(posedge clk) begin
        if (start) begin
            lat_r <= val_r;
            lat_g <= val_g;
            lat_b <= val_b;
            sr    <= {12'd0, val_r};
        end else if (state == CONV) begin
            if (iter == 3'd7) begin
                case (ch)
                    2'd0:    begin sh_r <= sr_step[19:8]; sr <= {12'd0, lat_g}; end
                    2'd1:    begin sh_g <= sr_step[19:8]; sr <= {12'd0, lat_b}; end
                    default: begin sh_b <= sr_step[19:8]; sr <= 20'd0; end
                endcase
            end else begin
                sr <= sr_step;
            end
        end
    end

    assign in_band = ({1'b0, line} >= Y0_W) && ({1'b0, line} < Y0_END);

    // Row generator: counter stage, then registered band decode.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            line      <= 10'd0;
            row_valid <= 1'b0;
            row_addr  <= 4'd0;
        end else begin
            if (frame_stb)
                line <= 10'd0;
            else if (line_stb && (line != 10'd1023))
                line <= line + 10'd1;
            row_valid <= in_band;
            row_addr  <= in_band ? (line[3:0] - Y0_LO) : 4'd0;
        end
    end

endmodule
